hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Consumes the ID/EX/WB register-match flags from the forwarding comparator. Turns them into:
//   - registered operand-forward selects for EX
//   - load-use stalls, data-memory wait holds and branch flushes
//  Sits between the comparator and the ID/EX pipeline register and forwarding muxes of the 16-bit core.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive dmem-not-ready cycles before mem_timeout_err sets
//  CNT_W        16  width of saturating stall_cycles counter
// PORTS
//  clk              in   1  single clock, rising edge
//  rst              in   1  synchronous active-high reset
//  id_rs1_eq_ex_rd  in   1  comparator flag
//  id_rs1_eq_wb_rd  in   1  comparator flag
//  id_rs2_eq_ex_rd  in   1  comparator flag
//  id_rs2_eq_wb_rd  in   1  comparator flag
//  if_rd_eq_wb_rd   in   1  comparator flag (register-file write-through)
//  id_rs1_used      in   1  ID instruction reads rs1
//  id_rs2_used      in   1  ID instruction reads rs2
//  ex_reg_wr        in   1  EX instruction writes rd
//  ex_is_load       in   1  EX instruction is a load
//  wb_reg_wr        in   1  WB instruction writes rd
//  branch_taken     in   1  EX resolved taken branch/jump
//  dmem_ready       in   1  data memory completes access this cycle
//  pc_stall         out  1  hold PC
//  if_id_stall      out  1  hold IF/ID register
//  if_id_flush      out  1  clear IF/ID to NOP
//  id_ex_bubble     out  1  load NOP into ID/EX
//  ex_hold          out  1  freeze ID/EX and EX/WB registers
//  fwd_a_sel        out  2  EX operand A: 00 regfile, 01 EX/WB result, 10 WB data
//  fwd_b_sel        out  2  EX operand B, same encoding
//  rf_bypass        out  1  registered: regfile read port takes WB write data
//  stall_cycles     out  CNT_W  saturating count of cycles with pc_stall=1
//  mem_timeout_err  out  1  sticky; cleared only by rst
// BEHAVIOUR
//  - Reset: state=RUN; fwd_*_sel=00, rf_bypass=0, stall_cycles=0, mem_timeout_err=0, wait_cnt=0. All comb outputs 0.
//  - Qualified matches: mEXa = id_rs1_used & ex_reg_wr & id_rs1_eq_ex_rd; mWBa = id_rs1_used & wb_reg_wr & id_rs1_eq_wb_rd. B likewise with rs2.
//  - Forward select (next): sel = mEX ? 01 : mWB ? 10 : 00. EX has priority over WB.
//  - Registered fwd_*_sel updates on every clock unless ex_hold. Forced to 00 when id_ex_bubble.
//  - rf_bypass <= wb_reg_wr & if_rd_eq_wb_rd; held under ex_hold.
//  - FSM states: RUN, LD_STALL, MEM_WAIT. Priority each cycle: MEM_WAIT cond > branch > load-use.
//  - MEM cond: ex_is_load & !dmem_ready.
//    - Outputs: ex_hold=pc_stall=if_id_stall=1. No flush or bubble.
//    - Enter/stay MEM_WAIT; wait_cnt++.
//    - wait_cnt reaching MEM_TIMEOUT sets mem_timeout_err. Counter saturates; state does not change.
//    - When dmem_ready: wait_cnt<=0, return RUN.
//  - Branch (branch_taken, not MEM cond): if_id_flush=1, id_ex_bubble=1 for that cycle; state RUN.
//    - A pending load-use in ID is discarded (flushed).
//  - Load-use (ex_is_load & (mEXa|mEXb), no MEM cond/branch):
//    - pc_stall=if_id_stall=id_ex_bubble=1 for exactly 1 cycle; state LD_STALL.
//    - Next cycle the load is in WB and the match resolves via fwd sel 10.
//  - LD_STALL: returns to RUN next cycle. A fresh load-use there is re-evaluated normally; never more than 1 bubble per load.
//  - stall_cycles increments when pc_stall=1 and saturates at all-ones.
//  - rst mid-stall: next cycle RUN; all holds drop; counters zero.
// STRUCTURE
//  - Shared package (core_pkg): FWD_REG=2'b00, FWD_EX=2'b01, FWD_WB=2'b10; state encoding localparams.
//  - One sub-module: hazard_fwd_sel (comb qualified-match + priority mux, instanced per operand).
//  - FSM, counters and output registers stay in top.
// TESTING
//  1. rst=1 two cycles with all inputs 1 -> all outputs 0, stall_cycles=0.
//  2. id_rs1_used, ex_reg_wr, rs1_eq_ex=1 and rs1_eq_wb=1, wb_reg_wr=1 -> fwd_a_sel=01 next cycle. With ex_reg_wr=0 -> 10.
//  3. ex_is_load, rs2_used, rs2_eq_ex=1 -> 1 cycle pc_stall/if_id_stall/id_ex_bubble; fwd_b_sel=00 that edge; stall_cycles=1.
//  4. ex_is_load with dmem_ready low 3 cycles -> ex_hold 3 cycles, fwd sel frozen, RUN on 4th, stall_cycles=3.
//  5. dmem_ready low 17 cycles (MEM_TIMEOUT=16) -> mem_timeout_err=1, stays 1 after ready, clears only on rst.
//  6. branch_taken with simultaneous load-use -> flush+bubble only, no pc_stall; with MEM cond also set -> hold only.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the 16-bit core hazard/forwarding logic.
package core_pkg;

    // Operand forward select encodings for the EX-stage muxes
    localparam logic [1:0] FWD_REG = 2'b00;  // register file read data
    localparam logic [1:0] FWD_EX  = 2'b01;  // EX/WB result
    localparam logic [1:0] FWD_WB  = 2'b10;  // WB write data

    // Hazard controller FSM state encodings
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_LD_STALL = 2'b01;
    localparam logic [1:0] ST_MEM_WAIT = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Qualified register-match and EX-over-WB priority select for one EX operand.
module hazard_fwd_sel
    import core_pkg::*;
(
    input  logic       rs_used,
    input  logic       ex_reg_wr,
    input  logic       wb_reg_wr,
    input  logic       eq_ex,
    input  logic       eq_wb,
    output logic       m_ex,
    output logic [1:0] sel
);

    logic m_wb;

    // A match only counts when the operand is read and the producer writes rd;
    // the younger EX producer wins over the older WB producer.
    always_comb begin
        m_ex = rs_used & ex_reg_wr & eq_ex;
        m_wb = rs_used & wb_reg_wr & eq_wb;
        if (m_ex)
            sel = FWD_EX;
        else if (m_wb)
            sel = FWD_WB;
        else
            sel = FWD_REG;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: turns comparator match flags into forward selects,
// load-use stalls, data-memory wait holds and branch flushes.
//
// Control outputs (pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold)
// are combinational and valid in the same cycle as the inputs; there is no
// valid/ready handshake, every input is a level sampled each cycle.
// Priority each cycle: memory wait > taken branch > load-use.
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_eq_ex_rd,
    input  logic             id_rs1_eq_wb_rd,
    input  logic             id_rs2_eq_ex_rd,
    input  logic             id_rs2_eq_wb_rd,
    input  logic             if_rd_eq_wb_rd,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_reg_wr,
    input  logic             ex_is_load,
    input  logic             wb_reg_wr,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             rf_bypass,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout_err,
    output logic [1:0]       fsm_state
);

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              m_ex_a;
    logic              m_ex_b;
    logic              mem_cond;
    logic              ld_use;

    hazard_fwd_sel u_fwd_a (
        .rs_used   (id_rs1_used),
        .ex_reg_wr (ex_reg_wr),
        .wb_reg_wr (wb_reg_wr),
        .eq_ex     (id_rs1_eq_ex_rd),
        .eq_wb     (id_rs1_eq_wb_rd),
        .m_ex      (m_ex_a),
        .sel       (sel_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_used   (id_rs2_used),
        .ex_reg_wr (ex_reg_wr),
        .wb_reg_wr (wb_reg_wr),
        .eq_ex     (id_rs2_eq_ex_rd),
        .eq_wb     (id_rs2_eq_wb_rd),
        .m_ex      (m_ex_b),
        .sel       (sel_b)
    );

    assign mem_cond  = ex_is_load & ~dmem_ready;
    assign ld_use    = ex_is_load & (m_ex_a | m_ex_b);
    assign fsm_state = state;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    // Next state: memory wait dominates, a branch flushes any pending load-use
    always_comb begin
        state_next = ST_RUN;
        if (mem_cond)
            state_next = ST_MEM_WAIT;
        else if (branch_taken)
            state_next = ST_RUN;
        else if (ld_use)
            state_next = ST_LD_STALL;
    end

    // Pipeline control outputs; all forced low while reset is asserted
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        if (!rst) begin
            if (mem_cond) begin
                ex_hold     = 1'b1;
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (ld_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Registered forward selects and regfile write-through, frozen while EX is held
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_sel <= FWD_REG;
            fwd_b_sel <= FWD_REG;
            rf_bypass <= 1'b0;
        end else if (!ex_hold) begin
            fwd_a_sel <= id_ex_bubble ? FWD_REG : sel_a;
            fwd_b_sel <= id_ex_bubble ? FWD_REG : sel_b;
            rf_bypass <= wb_reg_wr & if_rd_eq_wb_rd;
        end
    end

    // Memory-wait length counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else if (mem_cond) begin
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_MAX - 1'b1)
                mem_timeout_err <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Saturating count of PC stall cycles
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (pc_stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_rs1_eq_ex_rd, id_rs1_eq_wb_rd, id_rs2_eq_ex_rd, id_rs2_eq_wb_rd;
    logic        if_rd_eq_wb_rd, id_rs1_used, id_rs2_used;
    logic        ex_reg_wr, ex_is_load, wb_reg_wr, branch_taken, dmem_ready;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        rf_bypass;
    logic [15:0] stall_cycles;
    logic        mem_timeout_err;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_bad    = 0;

    hazard_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_eq_ex_rd (id_rs1_eq_ex_rd),
        .id_rs1_eq_wb_rd (id_rs1_eq_wb_rd),
        .id_rs2_eq_ex_rd (id_rs2_eq_ex_rd),
        .id_rs2_eq_wb_rd (id_rs2_eq_wb_rd),
        .if_rd_eq_wb_rd  (if_rd_eq_wb_rd),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_reg_wr       (ex_reg_wr),
        .ex_is_load      (ex_is_load),
        .wb_reg_wr       (wb_reg_wr),
        .branch_taken    (branch_taken),
        .dmem_ready      (dmem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_hold         (ex_hold),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .rf_bypass       (rf_bypass),
        .stall_cycles    (stall_cycles),
        .mem_timeout_err (mem_timeout_err),
        .fsm_state       (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic v);
        id_rs1_eq_ex_rd = v; id_rs1_eq_wb_rd = v; id_rs2_eq_ex_rd = v; id_rs2_eq_wb_rd = v;
        if_rd_eq_wb_rd  = v; id_rs1_used     = v; id_rs2_used     = v;
        ex_reg_wr = v; ex_is_load = v; wb_reg_wr = v; branch_taken = v; dmem_ready = v;
    endtask

    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        // order: pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold
        chk({tag, "_ctrl"}, 32'({pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold}),
            32'(exp));
    endtask

    initial begin
        // 1. reset with every input high
        rst = 1'b1;
        set_all(1'b1);
        tick();
        tick();
        #1;
        chk_ctrl("rst", 5'b00000);
        chk("rst_fwd_a", 32'(fwd_a_sel), 0);
        chk("rst_fwd_b", 32'(fwd_b_sel), 0);
        chk("rst_bypass", 32'(rf_bypass), 0);
        chk("rst_stall_cnt", 32'(stall_cycles), 0);
        chk("rst_err", 32'(mem_timeout_err), 0);
        chk("rst_state", 32'(fsm_state), 0);
        rst = 1'b0;
        set_all(1'b0);
        dmem_ready = 1'b1;
        tick();

        // 2. rs1 matches both EX and WB: EX wins; without EX write, WB
        id_rs1_used = 1; ex_reg_wr = 1; id_rs1_eq_ex_rd = 1; id_rs1_eq_wb_rd = 1; wb_reg_wr = 1;
        #1 chk_ctrl("fwd_ex", 5'b00000);
        tick();
        chk("fwd_a_ex", 32'(fwd_a_sel), 1);
        chk("fwd_b_idle", 32'(fwd_b_sel), 0);
        chk("bypass_off", 32'(rf_bypass), 0);
        ex_reg_wr = 0; if_rd_eq_wb_rd = 1;
        tick();
        chk("fwd_a_wb", 32'(fwd_a_sel), 2);
        chk("bypass_on", 32'(rf_bypass), 1);

        // 3. load-use on rs2: one bubble, then resolved from WB
        set_all(1'b0);
        dmem_ready = 1; ex_is_load = 1; ex_reg_wr = 1; id_rs2_used = 1; id_rs2_eq_ex_rd = 1;
        #1 chk_ctrl("ld_use", 5'b11010);
        tick();
        chk("ld_use_fwd_b", 32'(fwd_b_sel), 0);
        chk("ld_use_fwd_a", 32'(fwd_a_sel), 0);
        chk("ld_use_cnt", 32'(stall_cycles), 1);
        chk("ld_use_state", 32'(fsm_state), 1);
        ex_is_load = 0; ex_reg_wr = 0; wb_reg_wr = 1; id_rs2_eq_wb_rd = 1;
        #1 chk_ctrl("ld_after", 5'b00000);
        tick();
        chk("ld_after_fwd_b", 32'(fwd_b_sel), 2);
        chk("ld_after_state", 32'(fsm_state), 0);
        chk("ld_after_cnt", 32'(stall_cycles), 1);

        // 4. three-cycle memory wait freezes forward selects
        set_all(1'b0);
        dmem_ready = 1; id_rs1_used = 1; ex_reg_wr = 1; id_rs1_eq_ex_rd = 1;
        tick();
        chk("pre_wait_fwd_a", 32'(fwd_a_sel), 1);
        ex_reg_wr = 0; wb_reg_wr = 1; id_rs1_eq_wb_rd = 1;
        ex_is_load = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk_ctrl($sformatf("wait%0d", i), 5'b11001);
            tick();
            chk($sformatf("wait%0d_fwd_a", i), 32'(fwd_a_sel), 1);
            chk($sformatf("wait%0d_state", i), 32'(fsm_state), 2);
        end
        chk("wait_cnt3", 32'(stall_cycles), 4);
        dmem_ready = 1;
        #1 chk_ctrl("wait_done", 5'b00000);
        tick();
        chk("wait_done_state", 32'(fsm_state), 0);
        chk("wait_done_fwd_a", 32'(fwd_a_sel), 2);
        chk("wait_done_err", 32'(mem_timeout_err), 0);

        // 5. 17-cycle wait trips the sticky timeout
        dmem_ready = 0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 15) chk("tmo_before", 32'(mem_timeout_err), 0);
            if (i == 16) chk("tmo_at", 32'(mem_timeout_err), 1);
        end
        chk("tmo_cnt", 32'(stall_cycles), 21);
        dmem_ready = 1;
        tick();
        chk("tmo_sticky", 32'(mem_timeout_err), 1);
        chk("tmo_state", 32'(fsm_state), 0);

        // 6. branch over load-use, then memory wait over branch
        set_all(1'b0);
        dmem_ready = 1; ex_is_load = 1; ex_reg_wr = 1; id_rs2_used = 1; id_rs2_eq_ex_rd = 1;
        branch_taken = 1;
        #1 chk_ctrl("br_ld", 5'b00110);
        tick();
        chk("br_ld_state", 32'(fsm_state), 0);
        chk("br_ld_cnt", 32'(stall_cycles), 21);
        chk("br_ld_fwd_b", 32'(fwd_b_sel), 0);
        dmem_ready = 0;
        #1 chk_ctrl("br_mem", 5'b11001);
        tick();
        chk("br_mem_state", 32'(fsm_state), 2);
        chk("br_mem_cnt", 32'(stall_cycles), 22);

        // reset in the middle of a memory wait
        rst = 1;
        #1 chk_ctrl("rst_mid", 5'b00000);
        tick();
        rst = 0;
        set_all(1'b0);
        dmem_ready = 1;
        #1;
        chk("rst_mid_state", 32'(fsm_state), 0);
        chk("rst_mid_cnt", 32'(stall_cycles), 0);
        chk("rst_mid_err", 32'(mem_timeout_err), 0);
        chk_ctrl("rst_mid_idle", 5'b00000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
